// File: rtl/rx78_keyboard_if.sv
// CPU-side port F4 of the RX-78 keyboard: column strobe write and row byte read.
// kb_wr is a single-cycle strobe that is always accepted (no ready); kb_dout is combinational and needs no valid.
interface rx78_keyboard_if;
    logic       kb_wr;
    logic [7:0] kb_din;
    logic [7:0] kb_dout;

    modport master (output kb_wr, output kb_din, input kb_dout);
    modport slave  (input kb_wr, input kb_din, output kb_dout);
endinterface

// File: rtl/rx78_keyboard.sv
// PS/2 Set-2 receiver and scancode decoder feeding a 9x8 key matrix that the Z80 reads on port F4.
// rx_state exposes the receiver FSM (0 IDLE, 1 DATA, 2 PARITY, 3 STOP).
module rx78_keyboard #(
    parameter int FILTER  = 8,
    parameter int TIMEOUT = 50000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  ps2_clk,
    input  logic                  ps2_data,
    rx78_keyboard_if.slave        cpu,
    output logic                  scan_valid,
    output logic                  scan_err,
    output logic [1:0]            rx_state
);
    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} rx_state_t;

    localparam int FW = $clog2(FILTER + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [FW-1:0] FILT_MAX = FW'(FILTER - 1);
    localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT - 1);

    logic clk_s1, clk_s2, dat_s1, dat_s2;
    logic filt_clk, fall, fall_data;
    logic [FW-1:0] filt_cnt;

    rx_state_t state, state_d;
    logic [7:0] shreg, shreg_d;
    logic [2:0] bitcnt, bitcnt_d;
    logic par, par_d;
    logic [TW-1:0] to_cnt, to_cnt_d;
    logic valid_d, err_d;

    logic ext, brk;
    logic [71:0] matrix;
    logic [7:0] km;
    logic [3:0] colsel, col_idx;

    // Sync flops reset high so an idle bus never produces a spurious fall.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_clk  <= 1'b1;
            filt_cnt  <= '0;
            fall      <= 1'b0;
            fall_data <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (clk_s2 != filt_clk) begin
                if (filt_cnt == FILT_MAX) begin
                    filt_clk  <= clk_s2;
                    filt_cnt  <= '0;
                    fall      <= filt_clk;
                    fall_data <= dat_s2;
                end else begin
                    filt_cnt <= filt_cnt + 1'b1;
                end
            end else begin
                filt_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            shreg      <= '0;
            bitcnt     <= '0;
            par        <= 1'b0;
            to_cnt     <= '0;
            scan_valid <= 1'b0;
            scan_err   <= 1'b0;
        end else begin
            state      <= state_d;
            shreg      <= shreg_d;
            bitcnt     <= bitcnt_d;
            par        <= par_d;
            to_cnt     <= to_cnt_d;
            scan_valid <= valid_d;
            scan_err   <= err_d;
        end
    end

    // A fall always wins over the timeout and restarts the idle count.
    always_comb begin
        state_d  = state;
        shreg_d  = shreg;
        bitcnt_d = bitcnt;
        par_d    = par;
        to_cnt_d = to_cnt;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        if (fall) begin
            to_cnt_d = '0;
            case (state)
                S_IDLE: begin
                    if (!fall_data) begin
                        state_d  = S_DATA;
                        bitcnt_d = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                S_DATA: begin
                    shreg_d  = {fall_data, shreg[7:1]};
                    bitcnt_d = bitcnt + 1'b1;
                    if (bitcnt == 3'd7) state_d = S_PARITY;
                end
                S_PARITY: begin
                    par_d   = fall_data;
                    state_d = S_STOP;
                end
                S_STOP: begin
                    if (fall_data && (^{shreg, par})) valid_d = 1'b1;
                    else                             err_d   = 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state != S_IDLE) begin
            if (to_cnt == TO_MAX) begin
                state_d  = S_IDLE;
                to_cnt_d = '0;
            end else begin
                to_cnt_d = to_cnt + 1'b1;
            end
        end
    end

    assign rx_state = state;

    // {ext, code} -> {valid, col[3:0], row[2:0]}
    function automatic logic [7:0] keymap(input logic [8:0] key);
        case (key)
            9'h075: keymap = {1'b1, 4'd0, 3'd0};
            9'h016: keymap = {1'b1, 4'd0, 3'd1};
            9'h01E: keymap = {1'b1, 4'd0, 3'd2};
            9'h026: keymap = {1'b1, 4'd0, 3'd3};
            9'h01C: keymap = {1'b1, 4'd1, 3'd1};
            9'h032: keymap = {1'b1, 4'd1, 3'd2};
            9'h021: keymap = {1'b1, 4'd1, 3'd3};
            9'h023: keymap = {1'b1, 4'd1, 3'd4};
            9'h033: keymap = {1'b1, 4'd2, 3'd0};
            9'h043: keymap = {1'b1, 4'd2, 3'd1};
            9'h015: keymap = {1'b1, 4'd3, 3'd1};
            9'h02D: keymap = {1'b1, 4'd3, 3'd2};
            9'h022: keymap = {1'b1, 4'd4, 3'd0};
            9'h035: keymap = {1'b1, 4'd4, 3'd1};
            9'h04E: keymap = {1'b1, 4'd5, 3'd0};
            9'h029: keymap = {1'b1, 4'd6, 3'd0};
            9'h012: keymap = {1'b1, 4'd6, 3'd4};
            9'h05A: keymap = {1'b1, 4'd7, 3'd0};
            9'h005: keymap = {1'b1, 4'd7, 3'd1};
            9'h175: keymap = {1'b1, 4'd8, 3'd0};
            9'h172: keymap = {1'b1, 4'd8, 3'd1};
            9'h16B: keymap = {1'b1, 4'd8, 3'd2};
            9'h174: keymap = {1'b1, 4'd8, 3'd3};
            default: keymap = 8'h00;
        endcase
    endfunction

    assign km = keymap({ext, shreg});

    // Prefix flags persist until the next non-prefix byte, mapped or not.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ext    <= 1'b0;
            brk    <= 1'b0;
            matrix <= '0;
        end else if (scan_valid) begin
            if (shreg == 8'hE0) begin
                ext <= 1'b1;
            end else if (shreg == 8'hF0) begin
                brk <= 1'b1;
            end else begin
                if (km[7] && (km[6:3] <= 4'd8)) matrix[km[6:0]] <= ~brk;
                ext <= 1'b0;
                brk <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)       colsel <= '0;
        else if (cpu.kb_wr) colsel <= cpu.kb_din[3:0];
    end

    always_comb begin
        col_idx     = '0;
        cpu.kb_dout = 8'h00;
        if (colsel >= 4'd1 && colsel <= 4'd9) begin
            col_idx     = colsel - 4'd1;
            cpu.kb_dout = matrix[{col_idx, 3'b000} +: 8];
        end
    end
endmodule

// File: tb/tb_rx78_keyboard.sv
// Bench for rx78_keyboard: table of scancode sequences and column reads, plus hand-written
// sequences for timeout, start error, simultaneous write/update and mid-frame reset.
module tb_rx78_keyboard;
  localparam int FILTER  = 4;
  localparam int TIMEOUT = 2000;
  localparam int HALF    = 40;  // scaled PS/2 half bit period in clk cycles

  logic clk = 1'b0;
  logic reset_n;
  logic ps2_clk;
  logic ps2_data;
  logic scan_valid;
  logic scan_err;
  logic [1:0] rx_state;

  rx78_keyboard_if cpu_if ();

  rx78_keyboard #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .cpu        (cpu_if),
    .scan_valid (scan_valid),
    .scan_err   (scan_err),
    .rx_state   (rx_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q[$];  // {valid, err} per expected receiver pulse

  typedef struct {
    int         nb;
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
    logic       bad;
    logic [7:0] col;
    logic [7:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(input int nb, input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic bad, input logic [7:0] col,
                              input logic [7:0] exp, input string name);
    vec_t v;
    v.nb = nb; v.b0 = b0; v.b1 = b1; v.b2 = b2; v.bad = bad;
    v.col = col; v.exp = exp; v.name = name;
    return v;
  endfunction

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic ps2_bit(input logic b);
    @(negedge clk);
    ps2_data = b;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_par);
    logic p;
    p = ~(^b) ^ bad_par;
    exp_q.push_back(bad_par ? 2'b01 : 2'b10);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(p);
    ps2_bit(1'b1);
    repeat (HALF) @(negedge clk);
  endtask

  task automatic kb_write(input logic [7:0] v);
    @(negedge clk);
    cpu_if.kb_wr  = 1'b1;
    cpu_if.kb_din = v;
    @(negedge clk);
    cpu_if.kb_wr  = 1'b0;
  endtask

  // scoreboard: every receiver pulse must match the head of exp_q
  initial begin
    logic [1:0] e;
    forever begin
      @(negedge clk);
      if (reset_n && (scan_valid || scan_err)) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: got valid=%0b err=%0b expected none", scan_valid, scan_err);
        end else begin
          e = exp_q.pop_front();
          if ({scan_valid, scan_err} !== e) begin
            errors++;
            $display("FAIL scan_pulse: got valid=%0b err=%0b expected valid=%0b err=%0b",
                     scan_valid, scan_err, e[1], e[0]);
          end
        end
      end
    end
  end

  initial begin
    #(600_000);
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks + 1);
    $fatal(1);
  end

  initial begin
    int n;
    vecs[0]  = mk(1, 8'h1C, 8'h00, 8'h00, 1'b0, 8'h02, 8'h02, "make_1c");
    vecs[1]  = mk(0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h0A, 8'h00, "col_a_range");
    vecs[2]  = mk(2, 8'hF0, 8'h1C, 8'h00, 1'b0, 8'h02, 8'h00, "break_1c");
    vecs[3]  = mk(0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h0A, 8'h00, "col_a_after_break");
    vecs[4]  = mk(1, 8'h75, 8'h00, 8'h00, 1'b0, 8'h01, 8'h01, "make_75");
    vecs[5]  = mk(2, 8'hE0, 8'h75, 8'h00, 1'b0, 8'h09, 8'h01, "make_e0_75");
    vecs[6]  = mk(0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h01, 8'h01, "col0_kept");
    vecs[7]  = mk(3, 8'hE0, 8'hF0, 8'h75, 1'b0, 8'h09, 8'h00, "break_e0_75");
    vecs[8]  = mk(0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h01, 8'h01, "col0_survives");
    vecs[9]  = mk(1, 8'h5A, 8'h00, 8'h00, 1'b1, 8'h08, 8'h00, "bad_parity_5a");
    vecs[10] = mk(1, 8'h5A, 8'h00, 8'h00, 1'b0, 8'h08, 8'h01, "good_5a");
    vecs[11] = mk(1, 8'hAA, 8'h00, 8'h00, 1'b0, 8'h08, 8'h01, "bat_unmapped");
    vecs[12] = mk(1, 8'hFA, 8'h00, 8'h00, 1'b0, 8'h02, 8'h00, "ack_unmapped");

    reset_n       = 1'b0;
    ps2_clk       = 1'b1;
    ps2_data      = 1'b1;
    cpu_if.kb_wr  = 1'b0;
    cpu_if.kb_din = 8'h00;
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check8("reset_kb_dout", cpu_if.kb_dout, 8'h00);
    check8("reset_scan_valid", {7'd0, scan_valid}, 8'h00);
    check8("reset_scan_err", {7'd0, scan_err}, 8'h00);
    check8("reset_rx_state", {6'd0, rx_state}, 8'h00);

    foreach (vecs[i]) begin
      if (vecs[i].nb > 0) send_byte(vecs[i].b0, vecs[i].bad);
      if (vecs[i].nb > 1) send_byte(vecs[i].b1, 1'b0);
      if (vecs[i].nb > 2) send_byte(vecs[i].b2, 1'b0);
      kb_write(vecs[i].col);
      check8(vecs[i].name, cpu_if.kb_dout, vecs[i].exp);
    end

    // receiver timeout after 4 data bits, then a full frame
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    repeat (TIMEOUT + 100) @(negedge clk);
    check8("timeout_idle", {6'd0, rx_state}, 8'h00);
    send_byte(8'h1C, 1'b0);
    kb_write(8'h02);
    check8("after_timeout_1c", cpu_if.kb_dout, 8'h02);

    // stray fall with data high is a start-bit error
    exp_q.push_back(2'b01);
    ps2_bit(1'b1);
    repeat (HALF) @(negedge clk);
    check8("start_err_idle", {6'd0, rx_state}, 8'h00);

    // kb_wr on the same edge as the matrix update
    cpu_if.kb_din = 8'h00;
    fork
      send_byte(8'h32, 1'b0);
      begin
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!scan_valid && n < 3000);
        if (!scan_valid) begin
          checks++;
          errors++;
          $display("FAIL wait_scan_valid: got no pulse expected one within 3000 cycles");
        end else begin
          cpu_if.kb_wr  = 1'b1;
          cpu_if.kb_din = 8'h02;
          @(negedge clk);
          cpu_if.kb_wr  = 1'b0;
          check8("wr_with_update", cpu_if.kb_dout, 8'h06);
        end
      end
    join

    // reset mid-frame with keys held
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check8("rst_kb_dout", cpu_if.kb_dout, 8'h00);
    check8("rst_rx_state", {6'd0, rx_state}, 8'h00);
    kb_write(8'h02);
    check8("rst_col1", cpu_if.kb_dout, 8'h00);
    kb_write(8'h08);
    check8("rst_col7", cpu_if.kb_dout, 8'h00);
    kb_write(8'h01);
    check8("rst_col0", cpu_if.kb_dout, 8'h00);
    repeat (20) @(negedge clk);
    send_byte(8'h1C, 1'b0);
    kb_write(8'h02);
    check8("post_rst_1c", cpu_if.kb_dout, 8'h02);
    kb_write(8'h01);
    check8("post_rst_col0", cpu_if.kb_dout, 8'h00);

    repeat (100) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_pulses: got %0d left expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
